// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkg
// Description : Shared types, default constants and width helpers for the
//               RR interval unit and its sequential divider.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package rr_pkg;

    // Default rates and windows for a 360 Hz ECG front end
    localparam int RR_DEF_FS      = 360;
    localparam int RR_DEF_REFRACT = 72;
    localparam int RR_DEF_MAX_RR  = 1080;

    // Controller states: wait for a peak, divide, publish, update average
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_OUT  = 2'd2,
        ST_AVG  = 2'd3
    } rr_state_t;

    // Width of a {sign, integer, fraction} result word
    function automatic int rr_res_w(input int int_w, input int frac_w);
        return 1 + int_w + frac_w;
    endfunction

    // Ceiling log2, usable in constant expressions
    function automatic int rr_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring divider, one quotient bit per clock. Produces the
//               low Q_W bits of dividend/divisor and saturates to all ones
//               when the true quotient does not fit in Q_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import rr_pkg::*;
#(
    parameter int DVD_W = 27,
    parameter int DVS_W = 16,
    parameter int Q_W   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    // The dividend bits above the quotient window seed the remainder
    localparam int H_W   = DVD_W - Q_W;
    localparam int CMP_W = (H_W > DVS_W) ? H_W : DVS_W;
    localparam int STP_W = rr_clog2(Q_W + 1);
    localparam logic [STP_W-1:0] c_last = STP_W'(Q_W - 1);

    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [Q_W-1:0]   r_lo;
    logic [Q_W-1:0]   r_quo;
    logic [STP_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic             w_ovf;
    logic [DVS_W-1:0] w_rem_in;
    logic             w_bit_in;
    logic [DVS_W-1:0] w_dvs;
    logic [DVS_W:0]   w_trial;
    logic             w_fits;
    logic [DVS_W-1:0] w_rem_nxt;
    logic [Q_W-1:0]   w_quo_base;
    logic             w_last;

    // First step runs in the start cycle straight from the inputs, so the
    // quotient is ready exactly Q_W clocks after start.
    always_comb begin
        w_ovf      = CMP_W'(dividend[DVD_W-1:Q_W]) >= CMP_W'(divisor);
        w_rem_in   = start ? DVS_W'(dividend[DVD_W-1:Q_W]) : r_rem;
        w_bit_in   = start ? dividend[Q_W-1] : r_lo[Q_W-1];
        w_dvs      = start ? divisor : r_dvs;
        w_trial    = {w_rem_in, w_bit_in};
        w_fits     = w_trial >= {1'b0, w_dvs};
        w_rem_nxt  = DVS_W'(w_fits ? (w_trial - {1'b0, w_dvs}) : w_trial);
        w_quo_base = start ? '0 : r_quo;
        w_last     = start ? (c_last == '0) : (r_cnt == c_last);
    end

    // Shift/subtract iteration and done strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_lo   <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= (w_quo_base << 1) | Q_W'(w_fits);
                r_lo  <= (start ? dividend[Q_W-1:0] : r_lo) << 1;
                if (start) begin
                    r_dvs <= divisor;
                    r_ovf <= w_ovf;
                    r_cnt <= STP_W'(1);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_ovf ? '1 : r_quo;

endmodule
`default_nettype wire

// File: rtl/rr_interval_unit.sv
`default_nettype none
// ============================================================================
// Module      : rr_interval_unit
// Description : Measures samples between qualified R-peak rising edges and
//               converts them to seconds (sign/int/frac fixed point) with a
//               sequential divider. Adds refractory rejection, timeout
//               detection, saturation and a running average.
// Revision    : 1.0 - parametrised successor of the single-channel unit
// ============================================================================
module rr_interval_unit
    import rr_pkg::*;
#(
    parameter int FS        = RR_DEF_FS,
    parameter int CNT_W     = 16,
    parameter int INT_W     = 4,
    parameter int FRAC_W    = 11,
    parameter int AVG_DEPTH = 8,
    parameter int REFRACT   = RR_DEF_REFRACT,
    parameter int MAX_RR    = RR_DEF_MAX_RR
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_en,
    input  logic                                peak_detected,
    output logic [rr_res_w(INT_W, FRAC_W)-1:0]  rr_interval,
    output logic                                rr_valid,
    output logic [rr_res_w(INT_W, FRAC_W)-1:0]  rr_avg,
    output logic                                avg_valid,
    output logic                                busy,
    output logic                                artifact,
    output logic                                timeout
);

    localparam int Q_W     = INT_W + FRAC_W;
    localparam int AVG_LOG = rr_clog2(AVG_DEPTH);
    localparam int SUM_W   = Q_W + AVG_LOG;
    localparam int FILL_W  = rr_clog2(AVG_DEPTH + 1);
    localparam int DVD_W   = CNT_W + FRAC_W;

    localparam logic [CNT_W-1:0]  c_refract = CNT_W'(REFRACT);
    localparam logic [CNT_W-1:0]  c_max     = CNT_W'(MAX_RR);
    localparam logic [CNT_W-1:0]  c_sat     = CNT_W'(MAX_RR + 1);
    localparam logic [CNT_W-1:0]  c_fs      = CNT_W'(FS);
    localparam logic [FILL_W-1:0] c_depth   = FILL_W'(AVG_DEPTH);

    rr_state_t          r_state;
    logic               r_prev;
    logic               r_armed;
    logic [CNT_W-1:0]   r_elapsed;
    logic [Q_W-1:0]     r_buf [AVG_DEPTH];
    logic [AVG_LOG-1:0] r_wr_ptr;
    logic [FILL_W-1:0]  r_fill;
    logic [SUM_W-1:0]   r_sum;

    logic               w_edge;
    logic               w_busy;
    logic               w_arm;
    logic               w_accept;
    logic               w_clear;
    logic               w_artifact;
    logic               w_hit;
    logic               w_div_done;
    logic [Q_W-1:0]     w_div_q;
    logic [Q_W-1:0]     w_new;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic [FILL_W-1:0]  w_fill_nxt;

    // Classify each rising edge: arm, accept, or reject as an artifact
    always_comb begin
        w_edge     = peak_detected & ~r_prev;
        w_busy     = (r_state != ST_IDLE);
        w_arm      = w_edge && !w_busy && !r_armed;
        w_accept   = w_edge && !w_busy && r_armed &&
                     (r_elapsed >= c_refract) && (r_elapsed <= c_max);
        w_artifact = w_edge && (w_busy || (r_armed && (r_elapsed < c_refract)));
        // A refractory artifact keeps counting from the previous good peak
        w_clear    = w_edge && (w_busy || !r_armed || w_accept);
        w_hit      = sample_en && (r_elapsed == c_max) && !w_clear;
        w_new      = rr_interval[Q_W-1:0];
        w_sum_nxt  = r_sum - SUM_W'(r_buf[r_wr_ptr]) + SUM_W'(w_new);
        w_fill_nxt = (r_fill == c_depth) ? r_fill : (r_fill + 1'b1);
    end

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (CNT_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept),
        .dividend ({r_elapsed, {FRAC_W{1'b0}}}),
        .divisor  (c_fs),
        .done     (w_div_done),
        .quotient (w_div_q)
    );

    // Sample counter, arming/timeout tracking and the control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prev      <= 1'b0;
            r_armed     <= 1'b0;
            r_elapsed   <= '0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            rr_interval <= '0;
            rr_valid    <= 1'b0;
            rr_avg      <= '0;
            avg_valid   <= 1'b0;
            artifact    <= 1'b0;
            timeout     <= 1'b0;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_prev    <= peak_detected;
            rr_valid  <= 1'b0;
            avg_valid <= 1'b0;
            artifact  <= w_artifact;

            // Clearing wins over a same-cycle sample so the latched value
            // is the pre-increment count and counting restarts at zero
            if (w_clear) begin
                r_elapsed <= '0;
            end else if (sample_en && (r_elapsed != c_sat)) begin
                r_elapsed <= r_elapsed + 1'b1;
            end

            if (w_arm) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    rr_interval <= {1'b0, w_div_q};
                    rr_valid    <= 1'b1;
                    timeout     <= 1'b0;
                    r_state     <= ST_AVG;
                end
                ST_AVG: begin
                    // Buffer starts zeroed, so subtracting the slot is
                    // harmless while it is still filling
                    r_buf[r_wr_ptr] <= w_new;
                    r_sum           <= w_sum_nxt;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    r_fill          <= w_fill_nxt;
                    if (w_fill_nxt == c_depth) begin
                        avg_valid <= 1'b1;
                        rr_avg    <= {1'b0, w_sum_nxt[SUM_W-1:AVG_LOG]};
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Counter reaching MAX_RR+1 means the rhythm was lost
            if (w_hit) begin
                timeout <= 1'b1;
                r_armed <= 1'b0;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
